// File: rtl/ddr3_traffic_gen.sv
// Traffic generator and checker for the ddr3_core request port.
// Issues strided write / read / write-then-verify passes with address-derived
// data, tracks outstanding requests in an in-order ID FIFO and counts errors.
module ddr3_traffic_gen #(
  parameter int unsigned DATA_W          = 128,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned ID_W            = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic                  pattern_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [ADDR_W-1:0]     stride_i,
  input  logic [CNT_W-1:0]      count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      err_count_o,
  output logic [ADDR_W-1:0]     first_err_addr_o,
  output logic [DATA_W/8-1:0]   inport_wr_o,
  output logic                  inport_rd_o,
  output logic [ADDR_W-1:0]     inport_addr_o,
  output logic [DATA_W-1:0]     inport_write_data_o,
  output logic [ID_W-1:0]       inport_req_id_o,
  input  logic                  inport_accept_i,
  input  logic                  inport_ack_i,
  input  logic                  inport_error_i,
  input  logic [ID_W-1:0]       inport_resp_id_i,
  input  logic [DATA_W-1:0]     inport_read_data_i
);

  localparam int unsigned LANES = DATA_W / 32;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OST_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OST_W-1:0] OST_MAX  = OST_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WDRAIN,
    S_READ,
    S_RDRAIN,
    S_FIN
  } state_t;

  state_t                state_q;
  logic [1:0]            mode_q;
  logic                  pat_q;
  logic [ADDR_W-1:0]     base_q;
  logic [ADDR_W-1:0]     stride_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_W-1:0]     next_addr_q;
  logic [CNT_W-1:0]      issue_cnt_q;

  logic [DATA_W/8-1:0]   req_wr_q;
  logic                  req_rd_q;
  logic [ADDR_W-1:0]     req_addr_q;
  logic [DATA_W-1:0]     req_data_q;
  logic [ID_W-1:0]       req_id_q;
  logic [ID_W-1:0]       id_last_q;

  logic [OST_W-1:0]      outst_q;
  logic [OST_W-1:0]      outst_d;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [ID_W-1:0]       fifo_id_q   [MAX_OUTSTANDING];
  logic [ADDR_W-1:0]     fifo_addr_q [MAX_OUTSTANDING];
  logic                  fifo_rd_q   [MAX_OUTSTANDING];

  logic                  busy_q;
  logic                  done_q;
  logic [CNT_W-1:0]      err_cnt_q;
  logic [ADDR_W-1:0]     first_err_q;
  logic                  err_seen_q;

  logic                  req_vld;
  logic                  accept;
  logic                  ack_ok;
  logic                  stray_ack;
  logic                  issuing;
  logic                  load;
  logic [ID_W-1:0]       next_id;
  logic [ID_W-1:0]       pop_id;
  logic [ADDR_W-1:0]     pop_addr;
  logic                  pop_rd;
  logic [DATA_W-1:0]     exp_data;
  logic                  resp_bad;
  logic                  err_event;
  logic [ADDR_W-1:0]     err_addr;

  // Lane j of the beat at address a carries a + 4*j (mod 2^32), optionally inverted.
  function automatic logic [DATA_W-1:0] pattern_f(input logic [ADDR_W-1:0] a, input logic inv);
    logic [DATA_W-1:0] d;
    logic [31:0]       a32;
    a32 = 32'(a);
    d   = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      d[j*32 +: 32] = a32 + 32'(4 * j);
    end
    return inv ? ~d : d;
  endfunction

  assign req_vld   = req_rd_q | (|req_wr_q);
  assign accept    = req_vld & inport_accept_i;
  assign ack_ok    = inport_ack_i & (outst_q != '0);
  assign stray_ack = inport_ack_i & (outst_q == '0);
  assign issuing   = (state_q == S_WRITE) || (state_q == S_READ);

  assign pop_id    = fifo_id_q[rd_ptr_q];
  assign pop_addr  = fifo_addr_q[rd_ptr_q];
  assign pop_rd    = fifo_rd_q[rd_ptr_q];
  assign exp_data  = pattern_f(pop_addr, pat_q);

  // Outstanding count after this cycle; also gates whether a new request may be presented.
  always_comb begin
    outst_d = outst_q;
    if (accept && !ack_ok) begin
      outst_d = outst_q + OST_W'(1);
    end else if (!accept && ack_ok) begin
      outst_d = outst_q - OST_W'(1);
    end
  end

  // A new request is loaded when the output slot frees up this cycle and there is credit.
  // Its ID follows the request being accepted now, or the last accepted one otherwise.
  always_comb begin
    load    = issuing && (!req_vld || accept) && (issue_cnt_q != cnt_q) && (outst_d < OST_MAX);
    next_id = accept ? (req_id_q + ID_W'(1)) : (id_last_q + ID_W'(1));
  end

  // Response checking: error flag, ID mismatch, or read-data mismatch on the popped entry.
  always_comb begin
    resp_bad  = inport_error_i
              | (inport_resp_id_i != pop_id)
              | (pop_rd & (inport_read_data_i != exp_data));
    err_event = stray_ack | (ack_ok & resp_bad);
    err_addr  = stray_ack ? '0 : pop_addr;
  end

  // Run FSM, request presentation registers, outstanding tracking and FIFO pointers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      pat_q       <= 1'b0;
      base_q      <= '0;
      stride_q    <= '0;
      cnt_q       <= '0;
      next_addr_q <= '0;
      issue_cnt_q <= '0;
      req_wr_q    <= '0;
      req_rd_q    <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_id_q    <= '0;
      id_last_q   <= '0;
      outst_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      outst_q <= outst_d;
      done_q  <= (state_q == S_FIN);

      if (accept) begin
        id_last_q <= req_id_q;
        wr_ptr_q  <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (ack_ok) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end

      if (load) begin
        req_rd_q    <= (state_q == S_READ);
        req_wr_q    <= (state_q == S_READ) ? '0 : '1;
        req_addr_q  <= next_addr_q;
        req_data_q  <= (state_q == S_READ) ? '0 : pattern_f(next_addr_q, pat_q);
        req_id_q    <= next_id;
        next_addr_q <= next_addr_q + stride_q;
        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      end else if (accept) begin
        req_rd_q   <= 1'b0;
        req_wr_q   <= '0;
        req_addr_q <= '0;
        req_data_q <= '0;
        req_id_q   <= '0;
      end

      case (state_q)
        S_IDLE: begin
          busy_q <= start_i;
          if (start_i) begin
            mode_q      <= mode_i;
            pat_q       <= pattern_i;
            base_q      <= base_addr_i;
            stride_q    <= stride_i;
            cnt_q       <= count_i;
            next_addr_q <= base_addr_i;
            issue_cnt_q <= '0;
            if (count_i == '0) begin
              state_q <= S_FIN;
            end else if (mode_i == 2'd1) begin
              state_q <= S_READ;
            end else begin
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (accept && (issue_cnt_q == cnt_q)) begin
            state_q <= S_WDRAIN;
          end
        end
        S_WDRAIN: begin
          if (outst_q == '0) begin
            if (mode_q == 2'd0) begin
              state_q <= S_FIN;
            end else begin
              state_q     <= S_READ;
              next_addr_q <= base_q;
              issue_cnt_q <= '0;
            end
          end
        end
        S_READ: begin
          if (accept && (issue_cnt_q == cnt_q)) begin
            state_q <= S_RDRAIN;
          end
        end
        S_RDRAIN: begin
          if (outst_q == '0) begin
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // In-order record of accepted requests; storage needs no reset, pointers define emptiness.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_id_q[wr_ptr_q]   <= req_id_q;
      fifo_addr_q[wr_ptr_q] <= req_addr_q;
      fifo_rd_q[wr_ptr_q]   <= req_rd_q;
    end
  end

  // Per-run error statistics, cleared when a run starts.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt_q   <= '0;
      first_err_q <= '0;
      err_seen_q  <= 1'b0;
    end else if ((state_q == S_IDLE) && start_i) begin
      err_cnt_q   <= '0;
      first_err_q <= '0;
      err_seen_q  <= 1'b0;
    end else if (err_event) begin
      if (err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
      if (!err_seen_q) begin
        first_err_q <= err_addr;
        err_seen_q  <= 1'b1;
      end
    end
  end

  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign err_count_o         = err_cnt_q;
  assign first_err_addr_o    = first_err_q;
  assign inport_wr_o         = req_wr_q;
  assign inport_rd_o         = req_rd_q;
  assign inport_addr_o       = req_addr_q;
  assign inport_write_data_o = req_data_q;
  assign inport_req_id_o     = req_id_q;

endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// Scoreboard bench for ddr3_traffic_gen: expected requests are queued by the
// stimulus, a bus process plays the memory side and checks every accepted request.
module tb_ddr3_traffic_gen;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic          pattern = 1'b0;
  logic [31:0]   base = '0;
  logic [31:0]   stride = '0;
  logic [15:0]   count = '0;
  logic          busy, done;
  logic [15:0]   err_count;
  logic [31:0]   first_err;
  logic [15:0]   wr;
  logic          rd;
  logic [31:0]   addr;
  logic [127:0]  wdata;
  logic [15:0]   req_id;
  logic          accept = 1'b0;
  logic          ack = 1'b0;
  logic          rerror = 1'b0;
  logic [15:0]   resp_id = '0;
  logic [127:0]  rdata = '0;

  always #5 clk = ~clk;

  ddr3_traffic_gen #(
    .DATA_W(128),
    .ADDR_W(32),
    .ID_W(16),
    .MAX_OUTSTANDING(4),
    .CNT_W(16)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .start_i(start),
    .mode_i(mode),
    .pattern_i(pattern),
    .base_addr_i(base),
    .stride_i(stride),
    .count_i(count),
    .busy_o(busy),
    .done_o(done),
    .err_count_o(err_count),
    .first_err_addr_o(first_err),
    .inport_wr_o(wr),
    .inport_rd_o(rd),
    .inport_addr_o(addr),
    .inport_write_data_o(wdata),
    .inport_req_id_o(req_id),
    .inport_accept_i(accept),
    .inport_ack_i(ack),
    .inport_error_i(rerror),
    .inport_resp_id_i(resp_id),
    .inport_read_data_i(rdata)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  id;
    logic         rd;
  } req_t;

  typedef struct {
    logic [15:0] id;
    logic [31:0] addr;
    logic        rd;
    int          due;
  } rsp_t;

  req_t        exp_q[$];
  rsp_t        rsp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          ack_cnt = 0;
  int          done_cnt = 0;
  int          done_base = 0;
  int          stall_left = 0;
  logic [31:0] stall_addr = '0;
  bit          hold_acks = 1'b0;
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = '0;
  bit          id_bad = 1'b0;
  bit          run_pat = 1'b0;
  logic [15:0] next_id = 16'd1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  function automatic logic [127:0] tb_pat(input logic [31:0] a, input bit inv);
    logic [127:0] d;
    d = {a + 32'd12, a + 32'd8, a + 32'd4, a};
    return inv ? ~d : d;
  endfunction

  task automatic push_req(input logic [31:0] a, input logic [127:0] d, input logic [15:0] id, input logic r);
    req_t e;
    e.addr = a; e.data = d; e.id = id; e.rd = r;
    exp_q.push_back(e);
  endtask

  // Queue the full expected request stream of a run (addresses by multiplication).
  task automatic plan_run(input logic [1:0] m, input bit p, input logic [31:0] b,
                          input logic [31:0] s, input int n);
    logic [31:0] a;
    if (m != 2'd1) begin
      for (int k = 0; k < n; k++) begin
        a = b + 32'(k) * s;
        push_req(a, tb_pat(a, p), next_id, 1'b0);
        next_id++;
      end
    end
    if (m != 2'd0) begin
      for (int k = 0; k < n; k++) begin
        a = b + 32'(k) * s;
        push_req(a, '0, next_id, 1'b1);
        next_id++;
      end
    end
  endtask

  task automatic start_run(input logic [1:0] m, input bit p, input logic [31:0] b,
                           input logic [31:0] s, input int n);
    @(negedge clk);
    mode = m; pattern = p; base = b; stride = s; count = 16'(n);
    run_pat = p; acc_cnt = 0; ack_cnt = 0; done_base = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_acks,
                           input logic [15:0] exp_err, input logic [31:0] exp_first);
    int n;
    n = 0;
    while (done_cnt == done_base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, 128'(done_cnt != done_base), 128'(1));
    chk({name, "_acks_at_done"}, 128'(ack_cnt), 128'(exp_acks));
    repeat (3) @(negedge clk);
    chk({name, "_done_once"}, 128'(done_cnt - done_base), 128'(1));
    chk({name, "_err_count"}, 128'(err_count), 128'(exp_err));
    chk({name, "_first_err"}, 128'(first_err), 128'(exp_first));
    chk({name, "_all_issued"}, 128'(exp_q.size()), 128'(0));
    chk({name, "_busy_after"}, 128'(busy), 128'(0));
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_busy"}, 128'(busy), 128'(0));
    chk({name, "_done"}, 128'(done), 128'(0));
    chk({name, "_err"}, 128'(err_count), 128'(0));
    chk({name, "_first"}, 128'(first_err), 128'(0));
    chk({name, "_wr"}, 128'(wr), 128'(0));
    chk({name, "_rd"}, 128'(rd), 128'(0));
    chk({name, "_addr"}, 128'(addr), 128'(0));
    chk({name, "_data"}, wdata, 128'(0));
    chk({name, "_id"}, 128'(req_id), 128'(0));
  endtask

  // Memory-side model and monitor: decides accept, checks accepted requests, returns acks.
  initial begin
    bit   pend;
    req_t prev;
    req_t cur;
    req_t e;
    rsp_t r;
    bit   vld;
    bit   acc;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        accept = 1'b0;
        ack    = 1'b0;
        pend   = 1'b0;
      end else begin
        vld = rd | (|wr);
        cur.addr = addr; cur.data = wdata; cur.id = req_id; cur.rd = rd;
        if (pend && vld) begin
          chk("hold_addr", 128'(addr), 128'(prev.addr));
          chk("hold_data", wdata, prev.data);
          chk("hold_id", 128'(req_id), 128'(prev.id));
        end
        acc = 1'b1;
        if (vld && stall_left > 0 && addr == stall_addr) begin
          acc = 1'b0;
          stall_left--;
        end
        accept = acc;
        if (vld && acc) begin
          pend = 1'b0;
          acc_cnt++;
          chk("req_expected", 128'(exp_q.size() > 0), 128'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("req_addr", 128'(addr), 128'(e.addr));
            chk("req_data", wdata, e.data);
            chk("req_id", 128'(req_id), 128'(e.id));
            chk("req_rd", 128'(rd), 128'(e.rd));
            chk("req_wr", 128'(wr), e.rd ? 128'(0) : 128'(16'hFFFF));
          end
          r.id = req_id; r.addr = addr; r.rd = rd; r.due = cyc + 2;
          rsp_q.push_back(r);
        end else begin
          pend = vld;
          prev = cur;
        end
        if (!hold_acks && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
          r = rsp_q.pop_front();
          ack     = 1'b1;
          resp_id = id_bad ? r.id + 16'd1 : r.id;
          id_bad  = 1'b0;
          rdata   = r.rd ? tb_pat(r.addr, run_pat) : '0;
          if (r.rd && corrupt_en && r.addr == corrupt_addr) rdata = rdata ^ 128'd1;
          ack_cnt++;
        end else begin
          ack = 1'b0;
        end
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Write-only path with hand-computed vectors.
    push_req(32'h0,  128'h0000000C_00000008_00000004_00000000, 16'd1, 1'b0);
    push_req(32'h10, 128'h0000001C_00000018_00000014_00000010, 16'd2, 1'b0);
    push_req(32'h20, 128'h0000002C_00000028_00000024_00000020, 16'd3, 1'b0);
    push_req(32'h30, 128'h0000003C_00000038_00000034_00000030, 16'd4, 1'b0);
    next_id = 16'd5;
    start_run(2'd0, 1'b0, 32'h0, 32'h10, 4);
    wait_done("wonly", 4, 16'd0, 32'h0);

    // Backpressure on the third beat.
    stall_addr = 32'h120;
    stall_left = 3;
    plan_run(2'd0, 1'b0, 32'h100, 32'h10, 4);
    start_run(2'd0, 1'b0, 32'h100, 32'h10, 4);
    wait_done("bp", 4, 16'd0, 32'h0);
    chk("bp_stalls_used", 128'(stall_left), 128'(0));

    // Outstanding limit with acks withheld.
    hold_acks = 1'b1;
    plan_run(2'd0, 1'b0, 32'h1000, 32'h40, 8);
    start_run(2'd0, 1'b0, 32'h1000, 32'h40, 8);
    repeat (20) @(negedge clk);
    #1;
    chk("ost_accepted", 128'(acc_cnt), 128'(4));
    chk("ost_idle_rd", 128'(rd), 128'(0));
    chk("ost_idle_wr", 128'(wr), 128'(0));
    hold_acks = 1'b0;
    wait_done("ost", 8, 16'd0, 32'h0);

    // Write then verify, inverted pattern, corrupted read of beat 3.
    corrupt_en   = 1'b1;
    corrupt_addr = 32'h5030;
    plan_run(2'd2, 1'b1, 32'h5000, 32'h10, 8);
    start_run(2'd2, 1'b1, 32'h5000, 32'h10, 8);
    wait_done("verify", 16, 16'd1, 32'h5030);
    corrupt_en = 1'b0;

    // Zero-length run: done two cycles after start, no requests.
    start_run(2'd0, 1'b0, 32'h800, 32'h10, 0);
    #1;
    chk("cnt0_busy", 128'(busy), 128'(1));
    chk("cnt0_done_early", 128'(done), 128'(0));
    @(negedge clk);
    #1;
    chk("cnt0_done", 128'(done), 128'(1));
    repeat (3) @(negedge clk);
    chk("cnt0_no_req", 128'(acc_cnt), 128'(0));

    // Read-only run with an ID-mismatched first response.
    id_bad = 1'b1;
    plan_run(2'd1, 1'b0, 32'h200, 32'h4, 2);
    start_run(2'd1, 1'b0, 32'h200, 32'h4, 2);
    wait_done("idbad", 2, 16'd1, 32'h200);

    // Address wrap.
    push_req(32'hFFFF_FFF0, 128'hFFFFFFFC_FFFFFFF8_FFFFFFF4_FFFFFFF0, next_id, 1'b0);
    push_req(32'h0000_0000, 128'h0000000C_00000008_00000004_00000000, next_id + 16'd1, 1'b0);
    next_id = next_id + 16'd2;
    start_run(2'd0, 1'b0, 32'hFFFF_FFF0, 32'h10, 2);
    wait_done("wrap", 2, 16'd0, 32'h0);

    // Reset in the middle of a read pass.
    hold_acks = 1'b1;
    plan_run(2'd1, 1'b0, 32'h3000, 32'h10, 8);
    start_run(2'd1, 1'b0, 32'h3000, 32'h10, 8);
    n = 0;
    while (acc_cnt < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reads_started", 128'(acc_cnt >= 2), 128'(1));
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    exp_q.delete();
    rsp_q.delete();
    hold_acks = 1'b0;
    next_id   = 16'd1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_req(32'h40, 128'h0000004C_00000048_00000044_00000040, 16'd1, 1'b0);
    push_req(32'h50, 128'h0000005C_00000058_00000054_00000050, 16'd2, 1'b0);
    start_run(2'd0, 1'b0, 32'h40, 32'h10, 2);
    wait_done("postrst", 2, 16'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr3_traffic_gen.md
Name: ddr3_traffic_gen

Overview:
- Synthesizable traffic generator and checker for the ddr3_core request port.
- Issues parametrised write, read, or write-then-verify sequences with strided addresses and address-derived data patterns.
- Tracks outstanding requests, checks read data and response IDs, and reports pass/fail status.
- Used for on-board DDR bring-up and as a bench stimulus source.

Parameters:
- DATA_W, 128, request data width in bits (multiple of 32).
- ADDR_W, 32, address width.
- ID_W, 16, request/response ID width.
- MAX_OUTSTANDING, 4, max requests in flight (power of 2, 1..16).
- CNT_W, 16, width of the beat counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  begin a run (single-cycle pulse; ignored while busy_o=1).
- mode_i  in  2  run mode: 0=write only, 1=read+check only, 2=write pass then read+check pass, 3=reserved (treated as 2).
- pattern_i  in  1  data pattern: 0=address, 1=inverted address.
- base_addr_i  in  ADDR_W  first beat address.
- stride_i  in  ADDR_W  byte increment per beat.
- count_i  in  CNT_W  beats per pass.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at run end.
- err_count_o  out  CNT_W  mismatch + error count, saturating.
- first_err_addr_o  out  ADDR_W  address of the first failing beat.
- inport_wr_o  out  DATA_W/8  byte write strobes.
- inport_rd_o  out  1  read request.
- inport_addr_o  out  ADDR_W  request address.
- inport_write_data_o  out  DATA_W  write data.
- inport_req_id_o  out  ID_W  request ID.
- inport_accept_i  in  1  request accepted.
- inport_ack_i  in  1  response valid.
- inport_error_i  in  1  response error.
- inport_resp_id_i  in  ID_W  response ID.
- inport_read_data_i  in  DATA_W  read data.

Behaviour:
- Reset: all outputs 0.
  - Internal state: FSM=IDLE, beat/outstanding counters=0, req ID=0, ID FIFO empty.
- FSM states: IDLE, WRITE, WDRAIN, READ, RDRAIN, FIN.
  - IDLE -> start_i, mode 0/2/3 -> WRITE; mode 1 -> READ.
  - start_i with count_i=0 -> FIN directly; no requests issued.
  - WRITE -> WDRAIN after count_i writes accepted.
  - WDRAIN -> when outstanding=0: READ if mode 2/3, else FIN.
  - READ -> RDRAIN after count_i reads accepted.
  - RDRAIN -> FIN when outstanding=0.
  - FIN -> IDLE, with done_o=1 for exactly that cycle.
- busy_o=1 in every state except IDLE.
- start_i latches mode, pattern, base, stride and count. It also clears err_count_o and first_err_addr_o.
- Beat k address: base + k*stride, computed by accumulation and wrapping modulo 2^ADDR_W.
- Data for address A, lane j (32-bit lanes, j=0..DATA_W/32-1): A + 4*j, wrapping modulo 2^32.
  - pattern_i=1: bitwise inverse of the above.
- Write requests: inport_wr_o all ones; inport_rd_o=0.
- Read requests: inport_rd_o=1; inport_wr_o=0.
- Handshake:
  - A request is presented only when outstanding < MAX_OUTSTANDING.
  - Once presented, addr/data/id/strobes are held stable until the cycle inport_accept_i=1.
  - The next request may be presented the cycle after accept (back-to-back throughput 1/cycle).
- Request IDs: req ID increments by 1 per accepted request, wrapping at 2^ID_W. Each accepted request pushes {id, addr, is_read} into an in-order FIFO of depth MAX_OUTSTANDING.
- Outstanding counter:
  - +1 on accept, -1 on ack.
  - Simultaneous accept and ack leaves it unchanged.
  - An ack with outstanding=0 is ignored and counted as an error.
- On ack: pop the FIFO and increment err_count_o if any of these hold:
  - inport_error_i=1;
  - inport_resp_id_i differs from the popped ID;
  - the popped entry is a read and inport_read_data_i differs from the expected pattern for the popped address.
- first_err_addr_o: captured on the first error of the run only (popped address; 0 for a stray ack).
- err_count_o saturates at all ones.
- Asynchronous reset mid-run: returns immediately to the reset state. Late acks after reset with outstanding=0 are ignored.

Test Plan:
- Write-only path:
  - Stimulus: mode 0, base 0x0, stride 0x10, count 4, memory model with accept always 1 and ack 2 cycles later.
  - Required: addresses 0x0/0x10/0x20/0x30; beat 1 data = 0x0000001C_00000018_00000014_00000010.
  - Required: IDs 1..4; done_o pulses once; err_count_o=0.
- Backpressure:
  - Stimulus: hold inport_accept_i low for 3 cycles on beat 2.
  - Required: addr/data/id stable for all 4 presentation cycles; no beat skipped or duplicated.
- Outstanding limit:
  - Stimulus: MAX_OUTSTANDING=4, accept always 1, acks withheld for 20 cycles, count 8.
  - Required: exactly 4 requests accepted, then request lines idle until the first ack.
- Verify pass with a fault:
  - Stimulus: mode 2, pattern 1, base 0x5000, stride 0x10, count 8, model corrupts read data of beat 3.
  - Required: err_count_o=1, first_err_addr_o=0x5030, done_o after all 16 acks.
- Edge cases:
  - count 0 -> done_o 2 cycles after start with no requests.
  - An ID-mismatched response -> err_count_o increments.
  - Address wrap: base 0xFFFFFFF0, stride 0x10 -> second address 0x0.
- Reset mid-run:
  - Stimulus: assert rst_n_i low mid-READ.
  - Required: outputs 0 immediately.
  - Required: a new run after release completes with IDs restarting at 1.
